// File: rtl/seg_display_scan_if.sv
// Load/handshake and display-drive signals for seg_display_scan.
// The master side feeds ALU results; the slave side is the display block.
interface seg_display_scan_if;
  logic [7:0] value;
  logic       signed_mode;
  logic       ovf;
  logic       load;
  logic       busy;
  logic       done;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output value, signed_mode, ovf, load,
    input  busy, done, an, seg, dp
  );

  modport slave (
    input  value, signed_mode, ovf, load,
    output busy, done, an, seg, dp
  );
endinterface

// File: rtl/seg_display_scan.sv
// Registered ALU result display: double-dabble BCD conversion feeding
// a four-digit multiplexed active-low 7-segment scanner.
module seg_display_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  seg_display_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  localparam logic [17:0] TC = 18'(REFRESH_DIV - 1);
  localparam logic [3:0] SYM_DASH = 4'hA;
  localparam logic [3:0] SYM_BLANK = 4'hF;

  state_t      state, state_d;
  logic [2:0]  iter, iter_d;
  logic [19:0] sreg, sreg_d, adj;
  logic        neg_c, neg_d;
  logic        ovf_c, ovf_d;
  logic        neg_in;
  logic [7:0]  mag;

  logic [3:0]  dh, dt, du;
  logic        dneg, dovf;
  logic        done_q;

  logic [17:0] pcnt;
  logic        tick;
  logic        scan_on;
  logic [1:0]  idx, nidx;
  logic [3:0]  sym;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b1111111;
    case (d)
      4'd0:     s = 7'b1000000;
      4'd1:     s = 7'b1111001;
      4'd2:     s = 7'b0100100;
      4'd3:     s = 7'b0110000;
      4'd4:     s = 7'b0011001;
      4'd5:     s = 7'b0010010;
      4'd6:     s = 7'b0000010;
      4'd7:     s = 7'b1111000;
      4'd8:     s = 7'b0000000;
      4'd9:     s = 7'b0010000;
      SYM_DASH: s = 7'b0111111;
      default:  s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    neg_in = bus.signed_mode & bus.value[7];
    mag    = neg_in ? (~bus.value) + 8'd1 : bus.value;

    adj = sreg;
    if (sreg[19:16] >= 4'd5) adj[19:16] = sreg[19:16] + 4'd3;
    if (sreg[15:12] >= 4'd5) adj[15:12] = sreg[15:12] + 4'd3;
    if (sreg[11:8]  >= 4'd5) adj[11:8]  = sreg[11:8]  + 4'd3;

    state_d = state;
    iter_d  = iter;
    sreg_d  = sreg;
    neg_d   = neg_c;
    ovf_d   = ovf_c;

    unique case (state)
      IDLE: begin
        if (bus.load) begin
          state_d = CONVERT;
          iter_d  = 3'd0;
          sreg_d  = {12'd0, mag};
          neg_d   = neg_in;
          ovf_d   = bus.ovf;
        end
      end
      CONVERT: begin
        sreg_d = adj << 1;
        iter_d = iter + 3'd1;
        if (iter == 3'd7) state_d = UPDATE;
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      iter   <= 3'd0;
      sreg   <= 20'd0;
      neg_c  <= 1'b0;
      ovf_c  <= 1'b0;
      dh     <= 4'd0;
      dt     <= 4'd0;
      du     <= 4'd0;
      dneg   <= 1'b0;
      dovf   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      iter   <= iter_d;
      sreg   <= sreg_d;
      neg_c  <= neg_d;
      ovf_c  <= ovf_d;
      done_q <= (state == UPDATE);
      if (state == UPDATE) begin
        dh   <= sreg[19:16];
        dt   <= sreg[15:12];
        du   <= sreg[11:8];
        dneg <= neg_c;
        dovf <= ovf_c;
      end
    end
  end

  // Scanning stays dark until the first tick, which lands on digit 0.
  always_comb begin
    tick = (pcnt == TC);
    nidx = scan_on ? idx + 2'd1 : 2'd0;
    sym  = SYM_BLANK;
    if (dovf) begin
      sym = SYM_DASH;
    end else begin
      unique case (nidx)
        2'd0: sym = du;
        2'd1: sym = (dh == 4'd0 && dt == 4'd0) ? SYM_BLANK : dt;
        2'd2: sym = (dh == 4'd0) ? SYM_BLANK : dh;
        2'd3: sym = dneg ? SYM_DASH : SYM_BLANK;
        default: sym = SYM_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt    <= 18'd0;
      scan_on <= 1'b0;
      idx     <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      pcnt <= tick ? 18'd0 : pcnt + 18'd1;
      if (tick) begin
        scan_on <= 1'b1;
        idx     <= nidx;
        an_q    <= ~(4'b0001 << nidx);
        seg_q   <= enc(sym);
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_seg_display_scan.sv
// Randomised self-checking bench for seg_display_scan against a
// string-level model of the four displayed characters.
module tb_seg_display_scan;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  seg_display_scan_if bus();

  seg_display_scan #(.REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  function automatic string model(logic [7:0] v, logic sm, logic o);
    int    m;
    bit    neg;
    string s;
    string sg;
    if (o) return "----";
    neg = sm && v[7];
    m   = neg ? 256 - int'(v) : int'(v);
    s   = $sformatf("%3d", m);
    sg  = neg ? "-" : " ";
    return {sg, s};
  endfunction

  function automatic logic [6:0] glyph(byte c);
    case (c)
      "0": return 7'b1000000;
      "1": return 7'b1111001;
      "2": return 7'b0100100;
      "3": return 7'b0110000;
      "4": return 7'b0011001;
      "5": return 7'b0010010;
      "6": return 7'b0000010;
      "7": return 7'b1111000;
      "8": return 7'b0000000;
      "9": return 7'b0010000;
      "-": return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int an_index(logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check_display(string name, string exp);
    logic [3:0] seen;
    int         idx;
    seen = 4'b0000;
    repeat (DIV) tick1();
    for (int k = 0; k < 4; k++) begin
      idx = an_index(bus.an);
      n_cmp++;
      if (idx < 0) begin
        n_bad++;
        $display("FAIL %s an=%b required one-hot-low", name, bus.an);
      end else begin
        seen[idx] = 1'b1;
        n_cmp++;
        if (bus.seg !== glyph(exp[3-idx])) begin
          n_bad++;
          $display("FAIL %s digit%0d seg=%b required %b (\"%s\")",
                   name, idx, bus.seg, glyph(exp[3-idx]), exp);
        end
      end
      n_cmp++;
      if (bus.dp !== 1'b1) begin
        n_bad++;
        $display("FAIL %s dp=%b required 1", name, bus.dp);
      end
      repeat (DIV) tick1();
    end
    n_cmp++;
    if (seen !== 4'hF) begin
      n_bad++;
      $display("FAIL %s scan coverage=%b required 1111", name, seen);
    end
  endtask

  task automatic do_load(logic [7:0] v, logic sm, logic o);
    bus.value       = v;
    bus.signed_mode = sm;
    bus.ovf         = o;
    bus.load        = 1'b1;
    tick1();
    bus.load = 1'b0;
  endtask

  task automatic check_latency(string name);
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s cyc%0d busy=%b done=%b required busy=1 done=0",
                 name, k, bus.busy, bus.done);
      end
      tick1();
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s end busy=%b done=%b required busy=0 done=1",
               name, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    bus.value = 8'd0;
    bus.signed_mode = 1'b0;
    bus.ovf = 1'b0;
    bus.load = 1'b0;
    repeat (3) tick1();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.an !== 4'b1111 ||
        bus.seg !== 7'b1111111 || bus.dp !== 1'b1) begin
      n_bad++;
      $display("FAIL reset busy=%b done=%b an=%b seg=%b dp=%b required 0 0 1111 1111111 1",
               bus.busy, bus.done, bus.an, bus.seg, bus.dp);
    end
    rst = 1'b1;
    for (int k = 1; k < DIV; k++) begin
      tick1();
      n_cmp++;
      if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111) begin
        n_bad++;
        $display("FAIL pre_tick cyc%0d an=%b seg=%b required 1111 1111111",
                 k, bus.an, bus.seg);
      end
    end
    for (int p = 0; p < 4; p++) begin
      logic [3:0] ea;
      logic [6:0] es;
      repeat (p == 0 ? 1 : DIV) tick1();
      ea = ~(4'b0001 << p);
      es = (p == 0) ? 7'b1000000 : 7'b1111111;
      n_cmp++;
      if (bus.an !== ea || bus.seg !== es) begin
        n_bad++;
        $display("FAIL reset_scan p%0d an=%b seg=%b required %b %b",
                 p, bus.an, bus.seg, ea, es);
      end
    end
  endtask

  task automatic test_unsigned_max();
    do_load(8'hFF, 1'b0, 1'b0);
    check_latency("ff_latency");
    check_display("ff_disp", model(8'hFF, 1'b0, 1'b0));
  endtask

  task automatic test_signed_min();
    do_load(8'h80, 1'b1, 1'b0);
    check_latency("m128_latency");
    check_display("m128_disp", model(8'h80, 1'b1, 1'b0));
  endtask

  task automatic test_ignored_load();
    do_load(8'hF9, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_bad++;
        $display("FAIL ign cyc%0d busy=%b done=%b required 1 0", k, bus.busy, bus.done);
      end
      if (k == 3) begin
        bus.value = 8'h05;
        bus.signed_mode = 1'b0;
        bus.load = 1'b1;
      end
      tick1();
      bus.load = 1'b0;
    end
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL ign_done done=%b required 1", bus.done);
    end
    tick1();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ign_noqueue busy=%b required 0", bus.busy);
    end
    check_display("ign_disp", model(8'hF9, 1'b1, 1'b0));
  endtask

  task automatic test_overflow();
    do_load(8'h7F, 1'b0, 1'b1);
    check_latency("ovf_latency");
    check_display("ovf_disp", model(8'h7F, 1'b0, 1'b1));
  endtask

  task automatic test_back_to_back();
    bus.value = 8'd42;
    bus.signed_mode = 1'b0;
    bus.ovf = 1'b0;
    bus.load = 1'b1;
    tick1();
    check_latency("b2b_first");
    bus.value = 8'd199;
    tick1();
    bus.load = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_retrigger busy=%b done=%b required 1 0", bus.busy, bus.done);
    end
    repeat (8) tick1();
    tick1();
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second_done done=%b required 1", bus.done);
    end
    check_display("b2b_disp", model(8'd199, 1'b0, 1'b0));
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] v;
      logic       sm;
      logic       o;
      int         cyc;
      v   = 8'($urandom_range(0, 255));
      sm  = 1'($urandom_range(0, 1));
      o   = ($urandom_range(0, 7) == 0);
      do_load(v, sm, o);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 20) begin
        tick1();
        cyc++;
      end
      n_cmp++;
      if (cyc != 9) begin
        n_bad++;
        $display("FAIL rand%0d latency=%0d required 9 (v=%h sm=%b ovf=%b)",
                 i, cyc, v, sm, o);
      end
      check_display($sformatf("rand%0d_%h_%b%b", i, v, sm, o), model(v, sm, o));
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    do_load(8'h2A, 1'b0, 1'b0);
    repeat (4) tick1();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.an !== 4'b1111 ||
        bus.seg !== 7'b1111111 || bus.dp !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset busy=%b done=%b an=%b seg=%b dp=%b required 0 0 1111 1111111 1",
               bus.busy, bus.done, bus.an, bus.seg, bus.dp);
    end
    tick1();
    rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      tick1();
      if (bus.done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL mid_reset_done pulses=%0d required 0", dones);
    end
    check_display("mid_reset_disp", "   0");
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_min();
    test_ignored_load();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
